rv_branch_unit: RTL and testbench
=================================

Name: rv_branch_unit

Overview:
Parametrised branch resolution unit for the execute stage. It evaluates all six RV conditional branches directly on the operands, including the unsigned bltu/bgeu forms, and computes the target. It registers the resolution one cycle later and flags mispredictions against the fetch-time prediction. It also owns a PC-indexed table of 2-bit saturating counters (BHT) that serves fetch-side predictions, plus saturating performance counters.

Parameters:
XLEN, 64, operand/PC width
BHT_DEPTH, 64, number of BHT entries; power of 2, >= 2
CNT_W, 32, width of performance counters
BHT_INIT, 2'b01, reset value of every BHT entry (weakly not-taken)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-high reset
valid_i  input  1  branch instruction present this cycle
funct3_i  input  3  branch funct3
rs1_i  input  XLEN  operand 1
rs2_i  input  XLEN  operand 2
pc_i  input  XLEN  branch PC
imm_i  input  XLEN  sign-extended B-immediate
pred_taken_i  input  1  prediction made at fetch
kill_i  input  1  squash the instruction presented this cycle
fetch_pc_i  input  XLEN  fetch PC for BHT lookup
fetch_pred_o  output  1  predicted taken for fetch_pc_i
res_valid_o  output  1  resolution valid
taken_o  output  1  resolved direction
mispredict_o  output  1  taken_o != captured pred_taken_i
redirect_pc_o  output  XLEN  correct next PC
branch_cnt_o  output  CNT_W  resolved-branch count
mispred_cnt_o  output  CNT_W  mispredict count

Behaviour:
- Reset: rst_i is asynchronous and active-high. res_valid_o, taken_o, mispredict_o = 0. redirect_pc_o = 0. Both counters = 0. All BHT entries = BHT_INIT. An in-flight instruction is discarded.
- Condition by funct3:
  - 000 beq: rs1==rs2
  - 001 bne: rs1!=rs2
  - 100 blt: signed rs1<rs2
  - 101 bge: !(signed rs1<rs2)
  - 110 bltu: unsigned rs1<rs2
  - 111 bgeu: !(unsigned rs1<rs2)
  - 010 and 011 are illegal.
- Accept condition: valid_i & ~kill_i & legal funct3.
- Latency 1. At the rising edge where the accept condition holds:
  - res_valid_o <= 1
  - taken_o <= cond
  - mispredict_o <= cond ^ pred_taken_i
  - redirect_pc_o <= cond ? pc_i+imm_i : pc_i+4, both modulo 2^XLEN (wrap-around, no overflow flag)
- When the accept condition does not hold, res_valid_o, taken_o and mispredict_o <= 0 and redirect_pc_o holds its value. Back-to-back accepts yield back-to-back results.
- kill_i only squashes the instruction at the input. A result already on the outputs is unaffected. A killed or illegal instruction causes no BHT update and no counter change.
- BHT:
  - index = pc[IDX_W+1:2], where IDX_W = log2(BHT_DEPTH).
  - On accept, entry[index(pc_i)] moves toward 3 if taken and toward 0 if not taken, saturating at both ends.
  - fetch_pred_o = entry[index(fetch_pc_i)][1], purely combinational.
  - Same-cycle read and write of one index returns the pre-update value.
- Counters:
  - On accept, branch_cnt_o increments.
  - mispred_cnt_o increments when cond ^ pred_taken_i.
  - Both saturate at all-ones and never wrap.
  - Both update on the same edge as the result register.
- No backpressure. The consumer must take each result in its single valid cycle.

Test Plan:
- rs1=64'h1, rs2=64'hFFFF_FFFF_FFFF_FFFF: bltu -> taken_o=1. blt -> taken_o=0. bgeu -> 0. bge -> 1. Each result arrives one cycle after valid_i.
- beq with rs1=rs2=5, pc=0x1000, imm=0x20, pred_taken_i=0 -> next cycle res_valid_o=1, taken_o=1, mispredict_o=1, redirect_pc_o=0x1020, mispred_cnt_o=1.
- Wrap: pc=64'hFFFF_FFFF_FFFF_FFFC, bne not taken -> redirect_pc_o=0. Taken with imm=8 -> redirect_pc_o=4.
- BHT saturation: 4 taken branches at pc=0x40 -> counter 01→10→11→11. fetch_pc_i=0x40 gives fetch_pred_o=0 before the 1st edge and 1 after it. 3 not-taken branches then give 11→10→01→00, so fetch_pred_o=0. Aliasing: pc=0x40+4*BHT_DEPTH hits the same entry.
- Negative cases: kill_i=1 with valid_i=1, and funct3=010 -> res_valid_o=0 next cycle, BHT and counters unchanged. Asserting rst_i mid-stream clears outputs and counters immediately without waiting for a clock edge.
- Counter saturation with CNT_W=4: 20 accepted branches -> branch_cnt_o=4'hF and holds.

Source files
------------

// File: rtl/rv_branch_unit_if.sv
// Execute-stage branch unit port bundle: branch request, resolution, fetch-side
// BHT lookup and performance counters.
interface rv_branch_unit_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             valid_i;
  logic [2:0]       funct3_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [XLEN-1:0]  pc_i;
  logic [XLEN-1:0]  imm_i;
  logic             pred_taken_i;
  logic             kill_i;
  logic [XLEN-1:0]  fetch_pc_i;
  logic             fetch_pred_o;
  logic             res_valid_o;
  logic             taken_o;
  logic             mispredict_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  modport master (
    output valid_i, funct3_i, rs1_i, rs2_i, pc_i, imm_i, pred_taken_i, kill_i, fetch_pc_i,
    input  fetch_pred_o, res_valid_o, taken_o, mispredict_o, redirect_pc_o,
           branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  valid_i, funct3_i, rs1_i, rs2_i, pc_i, imm_i, pred_taken_i, kill_i, fetch_pc_i,
    output fetch_pred_o, res_valid_o, taken_o, mispredict_o, redirect_pc_o,
           branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/rv_branch_unit.sv
// RV conditional branch resolution with one-cycle registered result, a 2-bit
// saturating-counter BHT for fetch prediction and saturating perf counters.
module rv_branch_unit #(
  parameter int         XLEN      = 64,
  parameter int         BHT_DEPTH = 64,
  parameter int         CNT_W     = 32,
  parameter logic [1:0] BHT_INIT  = 2'b01
) (
  input logic         clk_i,
  input logic         rst_i,
  rv_branch_unit_if.slave bif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [1:0] bht_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic                   eq, lt_s, lt_u;
  logic                   cond, legal, accept, mispred;
  logic [XLEN-1:0]        target, fallthru;
  logic [IDX_W-1:0]       upd_idx, fetch_idx;

  assign rs1_s = bif.rs1_i;
  assign rs2_s = bif.rs2_i;
  assign eq    = (bif.rs1_i == bif.rs2_i);
  assign lt_s  = (rs1_s < rs2_s);
  assign lt_u  = (bif.rs1_i < bif.rs2_i);

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (bif.funct3_i)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = !lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = !lt_u;
      default: legal = 1'b0;
    endcase
  end

  assign accept   = bif.valid_i & ~bif.kill_i & legal;
  assign mispred  = cond ^ bif.pred_taken_i;
  assign target   = bif.pc_i + bif.imm_i;
  assign fallthru = bif.pc_i + INSN_BYTES;

  assign upd_idx   = bif.pc_i[IDX_W+1:2];
  assign fetch_idx = bif.fetch_pc_i[IDX_W+1:2];

  // Only the index bits of the fetch PC matter for the lookup.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{bif.fetch_pc_i[XLEN-1:IDX_W+2], bif.fetch_pc_i[1:0]};

  // ---- stage p1: registered resolution and counters ----
  logic             vld_p1, taken_p1, mispred_p1;
  logic [XLEN-1:0]  redirect_pc_p1;
  logic [CNT_W-1:0] branch_cnt_p1, mispred_cnt_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1         <= 1'b0;
      taken_p1       <= 1'b0;
      mispred_p1     <= 1'b0;
      redirect_pc_p1 <= '0;
      branch_cnt_p1  <= '0;
      mispred_cnt_p1 <= '0;
    end else begin
      vld_p1     <= accept;
      taken_p1   <= accept & cond;
      mispred_p1 <= accept & mispred;
      if (accept) begin
        redirect_pc_p1 <= cond ? target : fallthru;
        branch_cnt_p1  <= sat_inc(branch_cnt_p1);
        if (mispred) mispred_cnt_p1 <= sat_inc(mispred_cnt_p1);
      end
    end
  end

  // Reads see the pre-update entry when fetch and update share an index.
  logic [1:0] bht [BHT_DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= BHT_INIT;
    end else if (accept) begin
      bht[upd_idx] <= bht_next(bht[upd_idx], cond);
    end
  end

  assign bif.fetch_pred_o  = bht[fetch_idx][1];
  assign bif.res_valid_o   = vld_p1;
  assign bif.taken_o       = taken_p1;
  assign bif.mispredict_o  = mispred_p1;
  assign bif.redirect_pc_o = redirect_pc_p1;
  assign bif.branch_cnt_o  = branch_cnt_p1;
  assign bif.mispred_cnt_o = mispred_cnt_p1;

endmodule

// File: tb/tb_rv_branch_unit.sv
// Randomised + directed bench for rv_branch_unit with a queue-based scoreboard.
module tb_rv_branch_unit;
  localparam int XLEN  = 64;
  localparam int DEPTH = 64;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv_branch_unit_if #(.XLEN(XLEN), .CNT_W(CW)) bif ();

  rv_branch_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_W(CW), .BHT_INIT(2'b01)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bif  (bif)
  );

  typedef struct {
    logic        taken;
    logic        mis;
    logic [63:0] rpc;
    int          bc;
    int          mc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          m_bht[DEPTH];
  int          m_bc, m_mc;
  logic [63:0] m_rpc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bidx(input logic [63:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic logic model_legal(input logic [2:0] f);
    return !(f == 3'b010 || f == 3'b011);
  endfunction

  function automatic logic model_cond(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return !($signed(a) < $signed(b));
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
    m_bc  = 0;
    m_mc  = 0;
    m_rpc = '0;
    q.delete();
  endtask

  task automatic issue(input logic v, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] pc, input logic [63:0] imm, input logic pred,
                       input logic kill, input logic [63:0] fpc);
    logic        c;
    logic [63:0] tgt;
    int          ix;
    @(negedge clk);
    bif.valid_i      = v;
    bif.funct3_i     = f;
    bif.rs1_i        = a;
    bif.rs2_i        = b;
    bif.pc_i         = pc;
    bif.imm_i        = imm;
    bif.pred_taken_i = pred;
    bif.kill_i       = kill;
    bif.fetch_pc_i   = fpc;
    #1;
    check("fetch_pred", 64'(bif.fetch_pred_o), 64'(m_bht[bidx(fpc)] >= 2));
    if (v && !kill && model_legal(f)) begin
      c   = model_cond(f, a, b);
      tgt = c ? pc + imm : pc + 64'd4;
      if (m_bc < CMAX) m_bc++;
      if (c != pred && m_mc < CMAX) m_mc++;
      m_rpc = tgt;
      ix = bidx(pc);
      if (c) m_bht[ix] = (m_bht[ix] == 3) ? 3 : m_bht[ix] + 1;
      else   m_bht[ix] = (m_bht[ix] == 0) ? 0 : m_bht[ix] - 1;
      q.push_back('{taken: c, mis: c ^ pred, rpc: tgt, bc: m_bc, mc: m_mc});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bif.valid_i = 1'b0;
    bif.kill_i  = 1'b0;
  endtask

  // Call only when the previous cycle accepted nothing.
  task automatic idle_check(input logic [63:0] fpc);
    @(negedge clk);
    bif.valid_i    = 1'b0;
    bif.kill_i     = 1'b0;
    bif.fetch_pc_i = fpc;
    #1;
    check("idle_res_valid", 64'(bif.res_valid_o), 64'd0);
    check("idle_taken", 64'(bif.taken_o), 64'd0);
    check("idle_mispredict", 64'(bif.mispredict_o), 64'd0);
    check("idle_redirect_hold", bif.redirect_pc_o, m_rpc);
    check("idle_branch_cnt", 64'(bif.branch_cnt_o), 64'(m_bc));
    check("idle_mispred_cnt", 64'(bif.mispred_cnt_o), 64'(m_mc));
    check("idle_fetch_pred", 64'(bif.fetch_pred_o), 64'(m_bht[bidx(fpc)] >= 2));
  endtask

  task automatic do_reset();
    @(negedge clk);
    bif.valid_i = 1'b0;
    bif.kill_i  = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_res_valid", 64'(bif.res_valid_o), 64'd0);
    check("rst_taken", 64'(bif.taken_o), 64'd0);
    check("rst_mispredict", 64'(bif.mispredict_o), 64'd0);
    check("rst_redirect", bif.redirect_pc_o, 64'd0);
    check("rst_branch_cnt", 64'(bif.branch_cnt_o), 64'd0);
    check("rst_mispred_cnt", 64'(bif.mispred_cnt_o), 64'd0);
    model_reset();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bif.res_valid_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got res_valid_o=1 expected no result (t=%0t)", $time);
      end else begin
        mon_e = q.pop_front();
        check("taken", 64'(bif.taken_o), 64'(mon_e.taken));
        check("mispredict", 64'(bif.mispredict_o), 64'(mon_e.mis));
        check("redirect_pc", bif.redirect_pc_o, mon_e.rpc);
        check("branch_cnt", 64'(bif.branch_cnt_o), 64'(mon_e.bc));
        check("mispred_cnt", 64'(bif.mispred_cnt_o), 64'(mon_e.mc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b, pc, imm, fpc;
    logic [2:0]  f;
    rst              = 1'b1;
    bif.valid_i      = 1'b0;
    bif.funct3_i     = '0;
    bif.rs1_i        = '0;
    bif.rs2_i        = '0;
    bif.pc_i         = '0;
    bif.imm_i        = '0;
    bif.pred_taken_i = 1'b0;
    bif.kill_i       = 1'b0;
    bif.fetch_pc_i   = '0;
    model_reset();
    #1;
    check("por_res_valid", 64'(bif.res_valid_o), 64'd0);
    check("por_redirect", bif.redirect_pc_o, 64'd0);
    check("por_branch_cnt", 64'(bif.branch_cnt_o), 64'd0);
    check("por_fetch_pred", 64'(bif.fetch_pred_o), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // signed vs unsigned compare, back to back
    issue(1, 3'b110, 64'd1, ALL1, 64'h100, 64'h10, 1'b0, 1'b0, 64'h0);
    issue(1, 3'b100, 64'd1, ALL1, 64'h100, 64'h10, 1'b0, 1'b0, 64'h0);
    issue(1, 3'b111, 64'd1, ALL1, 64'h100, 64'h10, 1'b1, 1'b0, 64'h0);
    issue(1, 3'b101, 64'd1, ALL1, 64'h100, 64'h10, 1'b1, 1'b0, 64'h0);
    idle();
    do_reset();

    issue(1, 3'b000, 64'd5, 64'd5, 64'h1000, 64'h20, 1'b0, 1'b0, 64'h1000);
    idle();
    do_reset();

    // PC wrap-around on both the fall-through and target paths
    issue(1, 3'b001, 64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 1'b0, 1'b0, 64'h0);
    issue(1, 3'b001, 64'd7, 64'd8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1'b1, 1'b0, 64'h0);
    idle();
    idle_check(64'h0);

    // BHT saturation up then down through an aliasing PC
    do_reset();
    for (int i = 0; i < 4; i++)
      issue(1, 3'b000, 64'd3, 64'd3, 64'h40, 64'h8, 1'b1, 1'b0, 64'h40);
    for (int i = 0; i < 3; i++)
      issue(1, 3'b000, 64'd3, 64'd4, 64'h40 + 4 * DEPTH, 64'h8, 1'b0, 1'b0, 64'h40);
    idle();
    idle_check(64'h40);

    // squashed and illegal instructions leave BHT and counters alone
    issue(1, 3'b000, 64'd3, 64'd3, 64'h80, 64'h8, 1'b0, 1'b1, 64'h80);
    idle_check(64'h80);
    issue(1, 3'b010, 64'd3, 64'd3, 64'h80, 64'h8, 1'b0, 1'b0, 64'h80);
    idle_check(64'h80);
    issue(1, 3'b011, 64'd3, 64'd3, 64'h80, 64'h8, 1'b0, 1'b0, 64'h80);
    idle_check(64'h80);
    issue(1, 3'b000, 64'd3, 64'd3, 64'h200, 64'h40, 1'b0, 1'b0, 64'h80);
    issue(1, 3'b000, 64'd3, 64'd3, 64'h80, 64'h8, 1'b1, 1'b1, 64'h80);
    idle_check(64'h80);

    // reset while a result is on the outputs
    issue(1, 3'b000, 64'd9, 64'd9, 64'h300, 64'h4, 1'b0, 1'b0, 64'h0);
    do_reset();

    // counter saturation
    for (int i = 0; i < 20; i++)
      issue(1, 3'b001, 64'd1, 64'd2, 64'h500, 64'h4, 1'b0, 1'b0, 64'h0);
    idle();
    idle_check(64'h500);

    // random blocks
    for (int blk = 0; blk < 8; blk++) begin
      do_reset();
      for (int n = 0; n < 14; n++) begin
        f = 3'($urandom_range(7));
        a = {$urandom(), $urandom()};
        case ($urandom_range(3))
          0:       b = a;
          1:       b = a ^ 64'h8000_0000_0000_0000;
          default: b = {$urandom(), $urandom()};
        endcase
        pc  = {$urandom(), $urandom()};
        imm = ($urandom_range(1) == 1) ? {$urandom(), $urandom()} : 64'($signed(12'($urandom())));
        fpc = {$urandom(), 24'($urandom()), 6'($urandom_range(15)), 2'b00};
        if ($urandom_range(1) == 1) pc = {pc[63:8], 6'($urandom_range(15)), 2'b00};
        issue($urandom_range(7) != 0, f, a, b, pc, imm, 1'($urandom_range(1)),
              $urandom_range(9) == 0, fpc);
      end
      idle();
    end

    idle();
    idle();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
